// File: rtl/sar_scan_ctrl.sv
// Multi-channel successive-approximation controller: scans the enabled mux inputs,
// runs a WIDTH-bit binary search per channel against an external DAC/comparator.
module sar_scan_ctrl #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                continuous_i,
  input  logic                abort_i,
  input  logic [CHANNELS-1:0] ch_mask_i,
  input  logic                cmp_i,
  output logic [WIDTH-1:0]    dac_code_o,
  output logic [CH_W-1:0]     ch_sel_o,
  output logic                sample_o,
  output logic                busy_o,
  output logic                valid_o,
  output logic [WIDTH-1:0]    data_o,
  output logic [CH_W-1:0]     data_ch_o,
  output logic [1:0]          dbg_state_o
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, CONVERT = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CH_W-1:0]     ch_q, ch_d, data_ch_q, data_ch_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    code_q, code_d, data_q, data_d, trial;
  logic                new_found, nxt_found, go_sample;
  logic [CH_W-1:0]     new_ch, nxt_ch;

  // Lowest enabled channel of the live mask, and next higher channel of the latched mask.
  always_comb begin
    new_found = 1'b0;
    new_ch    = '0;
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!new_found && ch_mask_i[i]) begin
        new_found = 1'b1;
        new_ch    = CH_W'(i);
      end
      if (!nxt_found && mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  // start_i is a level request sampled on posedge; it is only acted on in IDLE with a
  // nonzero mask, and abort_i overrides it and every other transition.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    data_d    = data_q;
    data_ch_d = data_ch_q;
    go_sample = 1'b0;
    trial     = code_q | (WIDTH'(1) << bit_q);
    case (state_q)
      IDLE: begin
        if (start_i && new_found) begin
          mask_d    = ch_mask_i;
          ch_d      = new_ch;
          go_sample = 1'b1;
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d = CONVERT;
          bit_d   = BIT_W'(WIDTH - 1);
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          code_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CONVERT: begin
        if (cnt_q == '0) begin
          code_d = cmp_i ? trial : code_q;
          cnt_d  = CNT_W'(SETTLE_CYCLES - 1);
          if (bit_q == '0) begin
            state_d   = DONE;
            data_d    = cmp_i ? trial : code_q;
            data_ch_d = ch_q;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (nxt_found) begin
          ch_d      = nxt_ch;
          go_sample = 1'b1;
        end else if (continuous_i) begin
          mask_d = ch_mask_i;
          if (new_found) begin
            ch_d      = new_ch;
            go_sample = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_sample) begin
      state_d = SAMPLE;
      cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
      bit_d   = BIT_W'(WIDTH - 1);
      code_d  = '0;
    end
    if (abort_i) begin
      state_d   = IDLE;
      data_d    = data_q;
      data_ch_d = data_ch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      ch_q      <= '0;
      bit_q     <= BIT_W'(WIDTH - 1);
      cnt_q     <= '0;
      code_q    <= '0;
      data_q    <= '0;
      data_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      data_q    <= data_d;
      data_ch_q <= data_ch_d;
    end
  end

  always_comb begin
    case (state_q)
      CONVERT: dac_code_o = trial;
      DONE:    dac_code_o = code_q;
      default: dac_code_o = '0;
    endcase
  end

  assign ch_sel_o    = ch_q;
  assign sample_o    = (state_q == SAMPLE);
  assign busy_o      = (state_q != IDLE);
  assign valid_o     = (state_q == DONE);
  assign data_o      = data_q;
  assign data_ch_o   = data_ch_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench for sar_scan_ctrl: default 8-bit/4-channel instance plus a
// 10-bit, 3-cycle-settle instance, each with an ideal comparator model.
module tb_sar_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, cont = 1'b0, abort = 1'b0;
  logic [3:0] mask = 4'b0;
  logic       cmp;
  logic [7:0] dac_code, data;
  logic [1:0] ch_sel, data_ch, dbg_state;
  logic       sample, busy, valid;
  logic [7:0] vin [4];

  logic       start2 = 1'b0;
  logic [3:0] mask2 = 4'b0;
  logic       cmp2;
  logic [9:0] dac2, data2;
  logic [1:0] ch_sel2, data_ch2, dbg_state2;
  logic       sample2, busy2, valid2;
  logic [9:0] vin2 = 10'h2AA;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  localparam logic [7:0] A5_SEQ [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  assign cmp  = (vin[ch_sel] >= dac_code);
  assign cmp2 = (vin2 >= dac2);

  sar_scan_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .continuous_i(cont), .abort_i(abort),
    .ch_mask_i(mask), .cmp_i(cmp), .dac_code_o(dac_code), .ch_sel_o(ch_sel),
    .sample_o(sample), .busy_o(busy), .valid_o(valid), .data_o(data),
    .data_ch_o(data_ch), .dbg_state_o(dbg_state)
  );

  sar_scan_ctrl #(.WIDTH(10), .CHANNELS(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .continuous_i(1'b0), .abort_i(1'b0),
    .ch_mask_i(mask2), .cmp_i(cmp2), .dac_code_o(dac2), .ch_sel_o(ch_sel2),
    .sample_o(sample2), .busy_o(busy2), .valid_o(valid2), .data_o(data2),
    .data_ch_o(data_ch2), .dbg_state_o(dbg_state2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // drivers
  task automatic pulse_start(input logic [3:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_start2(input logic [3:0] m);
    @(negedge clk);
    mask2  = m;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({busy, valid, sample} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, valid, sample}); end
    total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL reset_dac: got %h want 00", dac_code); end
    total++; if ({data, data_ch, ch_sel} !== 12'h000) begin bad++; $display("FAIL reset_data: got %h want 000", {data, data_ch, ch_sel}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    vin[0] = 8'hA5;
    pulse_start(4'b0001);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      total++; if (valid !== (n == 11)) begin bad++; $display("FAIL single_valid_c%0d: got %b want %b", n, valid, (n == 11)); end
      if (n <= 2) begin
        total++; if ({sample, dac_code} !== {1'b1, 8'h00}) begin bad++; $display("FAIL single_sample_c%0d: got %b/%h want 1/00", n, sample, dac_code); end
      end else if (n <= 10) begin
        total++; if (dac_code !== A5_SEQ[n-3]) begin bad++; $display("FAIL single_dac_c%0d: got %h want %h", n, dac_code, A5_SEQ[n-3]); end
      end else begin
        total++; if (data !== 8'hA5 || data_ch !== 2'd0) begin bad++; $display("FAIL single_data: got %h ch%0d want a5 ch0", data, data_ch); end
        total++; if (dac_code !== 8'hA5) begin bad++; $display("FAIL single_done_dac: got %h want a5", dac_code); end
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_extremes();
    int n;
    vin[0] = 8'h00;
    pulse_start(4'b0001);
    wait_valid(n);
    total++; if (n !== 11 || data !== 8'h00) begin bad++; $display("FAIL extreme_zero: got n=%0d %h want n=11 00", n, data); end
    vin[0] = 8'hFF;
    pulse_start(4'b0001);
    wait_valid(n);
    total++; if (n !== 11 || data !== 8'hFF) begin bad++; $display("FAIL extreme_ff: got n=%0d %h want n=11 ff", n, data); end
  endtask

  task automatic test_scan();
    logic [7:0] e;
    int nval = 0;
    vin[1] = 8'h3C;
    vin[3] = 8'hC3;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    pulse_start(4'b1010);
    for (int n = 1; n <= 23; n++) begin
      @(negedge clk);
      if (valid) begin
        nval++;
        e = exp_q.pop_front();
        total++; if (n !== 11 * nval) begin bad++; $display("FAIL scan_strobe_time: got c%0d want c%0d", n, 11 * nval); end
        total++; if (data !== e || data_ch !== ((nval == 1) ? 2'd1 : 2'd3)) begin bad++; $display("FAIL scan_result%0d: got %h ch%0d want %h", nval, data, data_ch, e); end
      end
      if (n == 1 || n == 12) begin
        total++; if (sample !== 1'b1 || ch_sel !== ((n == 1) ? 2'd1 : 2'd3)) begin bad++; $display("FAIL scan_sample_c%0d: got %b ch%0d", n, sample, ch_sel); end
      end
      if (n == 13) begin
        total++; if (sample !== 1'b1) begin bad++; $display("FAIL scan_sample_c13: got %b want 1", sample); end
      end
      if (n == 23) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_idle_after: got %b want 0", busy); end
      end
    end
    total++; if (nval !== 2) begin bad++; $display("FAIL scan_count: got %0d want 2", nval); end
  endtask

  task automatic test_continuous();
    vin[0] = 8'h55;
    cont = 1'b1;
    pulse_start(4'b0001);
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      total++; if (valid !== (n == 11 || n == 22 || n == 33)) begin bad++; $display("FAIL cont_valid_c%0d: got %b", n, valid); end
      if (n == 11) begin
        total++; if (data !== 8'h55) begin bad++; $display("FAIL cont_r1: got %h want 55", data); end
      end
      if (n == 22) begin
        total++; if (data !== 8'h40) begin bad++; $display("FAIL cont_r2: got %h want 40", data); end
      end
      if (n == 33) begin
        total++; if (data !== 8'h10) begin bad++; $display("FAIL cont_r3: got %h want 10", data); end
      end
      if (n == 34) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_stop: got %b want 0", busy); end
      end
      if (n == 16) vin[0] = 8'h10;
      if (n == 25) cont = 1'b0;
    end
  endtask

  task automatic test_abort();
    vin[0] = 8'hA5;
    pulse_start(4'b0001);
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 6) begin
        total++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL abort_idle: got busy=%b st=%0d want 0/0", busy, dbg_state); end
        total++; if (data !== 8'h10 || data_ch !== 2'd0) begin bad++; $display("FAIL abort_data_kept: got %h want 10", data); end
        abort = 1'b0;
      end
      if (n > 5) begin
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_no_valid_c%0d: got %b want 0", n, valid); end
      end
      if (n == 5) abort = 1'b1;
    end
    vin[1] = 8'h3C;
    pulse_start(4'b1010);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 11) begin
        total++; if (valid !== 1'b1 || data !== 8'h3C) begin bad++; $display("FAIL abort_done_valid: got %b %h want 1 3c", valid, data); end
        abort = 1'b1;
      end
      if (n == 12) begin
        total++; if (busy !== 1'b0 || data !== 8'h3C) begin bad++; $display("FAIL abort_done_stop: got busy=%b %h want 0 3c", busy, data); end
        abort = 1'b0;
      end
    end
    abort = 1'b1;
    start = 1'b1;
    mask  = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_with_start: got %b want 0", busy); end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_start(4'b1010);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({busy, valid, sample, dac_code} !== 11'h000) begin bad++; $display("FAIL rstmid_ctrl: got %h want 000", {busy, valid, sample, dac_code}); end
    total++; if ({data, data_ch, ch_sel} !== 12'h000) begin bad++; $display("FAIL rstmid_data: got %h want 000", {data, data_ch, ch_sel}); end
    rst_n = 1'b1;
  endtask

  task automatic test_mask_zero();
    pulse_start(4'b0000);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mask_zero_c%0d: got %b want 0", n, busy); end
    end
  endtask

  task automatic test_wide();
    pulse_start2(4'b0001);
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      total++; if (valid2 !== (n == 33)) begin bad++; $display("FAIL wide_valid_c%0d: got %b", n, valid2); end
      if (n >= 3 && n <= 5) begin
        total++; if (dac2 !== 10'h200) begin bad++; $display("FAIL wide_dac_c%0d: got %h want 200", n, dac2); end
      end
      if (n >= 6 && n <= 8) begin
        total++; if (dac2 !== 10'h300) begin bad++; $display("FAIL wide_dac_c%0d: got %h want 300", n, dac2); end
      end
      if (n == 33) begin
        total++; if (data2 !== 10'h2AA) begin bad++; $display("FAIL wide_data: got %h want 2aa", data2); end
      end
      if (n == 34) begin
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL wide_idle_after: got %b want 0", busy2); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) vin[i] = 8'h00;
    test_reset();
    test_single();
    test_extremes();
    test_scan();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_mask_zero();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
